// File: rtl/uart_cmd_pkg.sv
// Shared state encodings and sizing helpers for the parametrised UART command receiver.
package uart_cmd_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK} asm_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam int BITS_PER_FRAME = 10;

  // Width of a counter that must hold every value from 0 up to max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 byte receiver: synchronises RX, confirms the start bit at half a bit time,
// then samples eight data bits (LSB first) and the stop bit at mid-bit.
module uart_rx
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] data_byte,
  output logic       byte_rdy,
  output logic       stop_err,
  output logic       start_det,
  output rx_state_t  state_o
);

  localparam int DW   = cnt_w(BAUD_DIV);
  localparam int HALF = BAUD_DIV / 2;

  logic            sync1_q, sync2_q, prev_q;
  rx_state_t       state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_rdy_q, byte_rdy_d;
  logic            stop_err_q, stop_err_d;
  logic            start_det_q, start_det_d;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q + 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    byte_rdy_d  = 1'b0;
    stop_err_d  = 1'b0;
    start_det_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        div_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        // A glitch shorter than half a bit returns to idle without a start_det.
        if (div_q == DW'(HALF - 1)) begin
          div_d = '0;
          if (!sync2_q) begin
            start_det_d = 1'b1;
            bit_d       = 3'd0;
            state_d     = RX_DATA;
          end else begin
            state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (div_q == DW'(BAUD_DIV - 1)) begin
          div_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (div_q == DW'(BAUD_DIV - 1)) begin
          div_d      = '0;
          state_d    = RX_IDLE;
          byte_rdy_d = sync2_q;
          stop_err_d = !sync2_q;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= RX_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_rdy_q  <= 1'b0;
      stop_err_q  <= 1'b0;
      start_det_q <= 1'b0;
    end else begin
      sync1_q     <= RX;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      byte_rdy_q  <= byte_rdy_d;
      stop_err_q  <= stop_err_d;
      start_det_q <= start_det_d;
    end
  end

  assign data_byte = shift_q;
  assign byte_rdy  = byte_rdy_q;
  assign stop_err  = stop_err_q;
  assign start_det = start_det_q;
  assign state_o   = state_q;

endmodule

// File: rtl/uart_cmd_rx_n.sv
// Assembles NUM_BYTES received bytes MSB-first into cmd, with optional checksum byte,
// inter-byte timeout, and a cmd/cmd_rdy/clr_cmd_rdy handoff to the command logic.
module uart_cmd_rx_n
  import uart_cmd_pkg::*;
#(
  parameter int NUM_BYTES   = 2,
  parameter int BAUD_DIV    = 2604,
  parameter int TIMEOUT_CYC = 104160,
  parameter int CHK_EN      = 0,
  parameter int CLR_ON_NEW  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   RX,
  input  logic                   clr_cmd_rdy,
  output logic [8*NUM_BYTES-1:0] cmd,
  output logic                   cmd_rdy,
  output logic                   chk_err,
  output logic                   frm_err,
  output logic                   overrun,
  output asm_state_t             dbg_asm_state,
  output rx_state_t              dbg_rx_state
);

  localparam int CW  = 8 * NUM_BYTES;
  localparam int BCW = cnt_w(NUM_BYTES);
  localparam int TW  = cnt_w(TIMEOUT_CYC);

  logic [7:0] rx_byte;
  logic       byte_rdy, stop_err, start_det;

  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX        (RX),
    .data_byte (rx_byte),
    .byte_rdy  (byte_rdy),
    .stop_err  (stop_err),
    .start_det (start_det),
    .state_o   (dbg_rx_state)
  );

  asm_state_t     state_q, state_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d, cnt_next;
  logic [CW-1:0]  shadow_q, shadow_d, cmd_q, cmd_d;
  logic [7:0]     sum_q, sum_d, sum_next;
  logic [TW-1:0]  timer_q, timer_d;
  logic           commit_q, commit_d;
  logic           cmd_rdy_q, cmd_rdy_d;
  logic           chk_err_q, chk_err_d, frm_err_q, frm_err_d, overrun_q, overrun_d;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shadow_d   = shadow_q;
    sum_d      = sum_q;
    timer_d    = (state_q == IDLE || byte_rdy) ? '0 : timer_q + 1'b1;
    commit_d   = 1'b0;
    chk_err_d  = 1'b0;
    frm_err_d  = 1'b0;
    cnt_next   = (state_q == IDLE) ? BCW'(1) : byte_cnt_q + 1'b1;
    sum_next   = ((state_q == IDLE) ? 8'h00 : sum_q) + rx_byte;
    case (state_q)
      IDLE, COLLECT: begin
        if (byte_rdy) begin
          shadow_d   = CW'({shadow_q, rx_byte});
          sum_d      = sum_next;
          byte_cnt_d = cnt_next;
          if (cnt_next == BCW'(NUM_BYTES)) begin
            if (CHK_EN != 0) begin
              state_d = CHECK;
            end else begin
              commit_d = 1'b1;
              state_d  = IDLE;
            end
          end else begin
            state_d = COLLECT;
          end
        end
      end
      CHECK: begin
        // The checksum byte never enters the shadow register.
        if (byte_rdy) begin
          commit_d  = (sum_next == 8'h00);
          chk_err_d = (sum_next != 8'h00);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && !byte_rdy && timer_q == TW'(TIMEOUT_CYC)) begin
      frm_err_d = 1'b1;
      state_d   = IDLE;
    end
    if (stop_err) begin
      frm_err_d = 1'b1;
      state_d   = IDLE;
    end
  end

  // Handoff: cmd_rdy=1 means cmd holds a valid command; the consumer acknowledges with a
  // one-cycle clr_cmd_rdy. A commit in the same cycle as a clear wins and keeps cmd_rdy set.
  always_comb begin
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    overrun_d = 1'b0;
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    if (CLR_ON_NEW != 0 && start_det && state_q == IDLE) cmd_rdy_d = 1'b0;
    if (commit_q) begin
      cmd_d     = shadow_q;
      cmd_rdy_d = 1'b1;
      overrun_d = (CLR_ON_NEW == 0) && cmd_rdy_q && !clr_cmd_rdy;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      shadow_q   <= '0;
      sum_q      <= '0;
      timer_q    <= '0;
      commit_q   <= 1'b0;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
      chk_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shadow_q   <= shadow_d;
      sum_q      <= sum_d;
      timer_q    <= timer_d;
      commit_q   <= commit_d;
      cmd_q      <= cmd_d;
      cmd_rdy_q  <= cmd_rdy_d;
      chk_err_q  <= chk_err_d;
      frm_err_q  <= frm_err_d;
      overrun_q  <= overrun_d;
    end
  end

  assign cmd           = cmd_q;
  assign cmd_rdy       = cmd_rdy_q;
  assign chk_err       = chk_err_q;
  assign frm_err       = frm_err_q;
  assign overrun       = overrun_q;
  assign dbg_asm_state = state_q;

endmodule

// File: tb/tb_uart_cmd_rx_n.sv
// Directed bench for three receiver configurations sharing one clock and reset,
// checked against a frame-level model plus hand-computed literal expectations.
module tb_uart_cmd_rx_n;
  import uart_cmd_pkg::*;

  localparam int BD = 16;
  localparam int TO = 400;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [2:0]  rx_v, clr_v;
  logic [15:0] cmd_a, cmd_c;
  logic [31:0] cmd_b;
  logic [2:0]  rdy_v, chk_v, frm_v, ovr_v;
  asm_state_t  st_a, st_b, st_c;
  rx_state_t   rs_a, rs_b, rs_c;
  logic [31:0] cmd_v [3];

  assign cmd_v[0] = {16'h0, cmd_a};
  assign cmd_v[1] = cmd_b;
  assign cmd_v[2] = {16'h0, cmd_c};

  // A: 2 bytes, legacy clear; B: 4 bytes + checksum; C: 2 bytes, hold until ack.
  uart_cmd_rx_n #(.NUM_BYTES(2), .BAUD_DIV(BD), .TIMEOUT_CYC(TO), .CHK_EN(0), .CLR_ON_NEW(1)) u_a (
    .clk(clk), .rst_n(rst_n), .RX(rx_v[0]), .clr_cmd_rdy(clr_v[0]), .cmd(cmd_a),
    .cmd_rdy(rdy_v[0]), .chk_err(chk_v[0]), .frm_err(frm_v[0]), .overrun(ovr_v[0]),
    .dbg_asm_state(st_a), .dbg_rx_state(rs_a));
  uart_cmd_rx_n #(.NUM_BYTES(4), .BAUD_DIV(BD), .TIMEOUT_CYC(TO), .CHK_EN(1), .CLR_ON_NEW(1)) u_b (
    .clk(clk), .rst_n(rst_n), .RX(rx_v[1]), .clr_cmd_rdy(clr_v[1]), .cmd(cmd_b),
    .cmd_rdy(rdy_v[1]), .chk_err(chk_v[1]), .frm_err(frm_v[1]), .overrun(ovr_v[1]),
    .dbg_asm_state(st_b), .dbg_rx_state(rs_b));
  uart_cmd_rx_n #(.NUM_BYTES(2), .BAUD_DIV(BD), .TIMEOUT_CYC(TO), .CHK_EN(0), .CLR_ON_NEW(0)) u_c (
    .clk(clk), .rst_n(rst_n), .RX(rx_v[2]), .clr_cmd_rdy(clr_v[2]), .cmd(cmd_c),
    .cmd_rdy(rdy_v[2]), .chk_err(chk_v[2]), .frm_err(frm_v[2]), .overrun(ovr_v[2]),
    .dbg_asm_state(st_c), .dbg_rx_state(rs_c));

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [33:0] exp_q[$];  // {dut index, expected cmd} in commit order

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  int          m_cnt [3] = '{0, 0, 0};
  logic [31:0] m_acc [3];
  logic [7:0]  m_sum [3];
  bit          m_rdy [3] = '{0, 0, 0};
  int exp_frm [3] = '{0, 0, 0};
  int exp_chk [3] = '{0, 0, 0};
  int exp_ovr [3] = '{0, 0, 0};

  function automatic int nb(input int d);
    return (d == 1) ? 4 : 2;
  endfunction
  function automatic bit chk_en(input int d);
    return d == 1;
  endfunction
  function automatic bit clr_new(input int d);
    return d != 2;
  endfunction

  function automatic void model_commit(input int d);
    if (!clr_new(d) && m_rdy[d] && !clr_v[d]) exp_ovr[d]++;
    m_rdy[d] = 1'b1;
    exp_q.push_back({2'(d), m_acc[d]});
    m_cnt[d] = 0;
  endfunction

  function automatic void model_start(input int d);
    if (m_cnt[d] == 0 && clr_new(d)) m_rdy[d] = 1'b0;
  endfunction

  function automatic void model_byte(input int d, input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) begin
      exp_frm[d]++;
      m_cnt[d] = 0;
    end else if (m_cnt[d] < nb(d)) begin
      if (m_cnt[d] == 0) begin
        m_acc[d] = '0;
        m_sum[d] = '0;
      end
      m_acc[d] = (m_acc[d] << 8) | 32'(b);
      m_sum[d] = m_sum[d] + b;
      m_cnt[d]++;
      if (m_cnt[d] == nb(d) && !chk_en(d)) model_commit(d);
    end else begin
      if (8'(m_sum[d] + b) == 8'h00) model_commit(d);
      else begin
        exp_chk[d]++;
        m_cnt[d] = 0;
      end
    end
  endfunction

  function automatic void model_timeout(input int d);
    if (m_cnt[d] != 0) begin
      exp_frm[d]++;
      m_cnt[d] = 0;
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      m_cnt[d] = 0;
      m_rdy[d] = 1'b0;
    end
  endfunction

  // ---------------- compare process ----------------
  int          frm_seen [3] = '{0, 0, 0};
  int          chk_seen [3] = '{0, 0, 0};
  int          ovr_seen [3] = '{0, 0, 0};
  int          rdy_hi   [3] = '{0, 0, 0};
  logic [31:0] prev_cmd [3];
  logic        prev_rdy [3];
  logic [33:0] cmp_e;
  bit          cmp_commit;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) begin
        prev_cmd[d] = '0;
        prev_rdy[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        cmp_commit = (rdy_v[d] && !prev_rdy[d]) || ovr_v[d] || (cmd_v[d] !== prev_cmd[d]);
        if (cmp_commit) begin
          if (exp_q.size() == 0) begin
            check("unexpected_commit", {d[1:0], cmd_v[d]}, 64'hdead);
          end else begin
            cmp_e = exp_q.pop_front();
            check("commit_cmd", {d[1:0], cmd_v[d]}, cmp_e);
          end
        end
        if (frm_v[d]) frm_seen[d]++;
        if (chk_v[d]) chk_seen[d]++;
        if (ovr_v[d]) ovr_seen[d]++;
        if (rdy_v[d] && clr_v[d]) rdy_hi[d]++;
        prev_cmd[d] = cmd_v[d];
        prev_rdy[d] = rdy_v[d];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, input bit stop_bit,
                           output logic rdy_at_start);
    model_start(d);
    rx_v[d] = 1'b0;
    idle(BD);
    rdy_at_start = rdy_v[d];
    for (int i = 0; i < 8; i++) begin
      rx_v[d] = b[i];
      idle(BD);
    end
    model_byte(d, b, stop_bit);
    rx_v[d] = stop_bit;
    idle(BD);
    rx_v[d] = 1'b1;
  endtask

  task automatic send_frame(input int d, input logic [39:0] bytes, input int n);
    logic r;
    for (int i = 0; i < n; i++) begin
      send_byte(d, bytes[8*(n-1-i) +: 8], 1'b1, r);
      idle(BD);
    end
  endtask

  task automatic pulse_clr(input int d);
    clr_v[d] = 1'b1;
    @(negedge clk);
    clr_v[d] = 1'b0;
    m_rdy[d] = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    for (int d = 0; d < 3; d++) begin
      check({name, "_cmd"}, cmd_v[d], 64'h0);
      check({name, "_rdy"}, rdy_v[d], 64'h0);
      check({name, "_pulses"}, {chk_v[d], frm_v[d], ovr_v[d]}, 64'h0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic r;
    rst_n = 1'b0;
    rx_v  = 3'b111;
    clr_v = 3'b000;
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    // Basic two-byte frame; cmd_rdy must be up before the stop bit ends.
    send_byte(0, 8'hAB, 1'b1, r);
    idle(BD);
    send_byte(0, 8'hCD, 1'b1, r);
    check("a_rdy_by_stop_end", rdy_v[0], 1);
    check("a_cmd_abcd", cmd_a, 16'hABCD);
    idle(BD);
    send_byte(0, 8'h12, 1'b1, r);
    check("a_rdy_cleared_on_start", r, 0);
    check("a_cmd_held_mid_frame", cmd_a, 16'hABCD);
    idle(BD);
    send_byte(0, 8'h34, 1'b1, r);
    idle(4);
    check("a_cmd_1234", cmd_a, 16'h1234);
    check("a_rdy_1234", rdy_v[0], 1);

    // Checksum: DE+AD+BE+EF = 0x338, low byte 0x38, so 0xC8 completes the sum to 0x00.
    send_frame(1, 40'hDEADBEEFC8, 5);
    check("b_cmd_deadbeef", cmd_b, 32'hDEADBEEF);
    check("b_rdy_good_chk", rdy_v[1], 1);
    check("b_no_chk_err", chk_seen[1], 0);
    send_frame(1, 40'hDEADBEEFC9, 5);
    check("b_chk_err_once", chk_seen[1], 1);
    check("b_rdy_after_bad", rdy_v[1], 0);
    check("b_cmd_kept", cmd_b, 32'hDEADBEEF);

    // Inter-byte timeout drops the lone 0x55.
    send_byte(0, 8'h55, 1'b1, r);
    idle(TO + 10);
    model_timeout(0);
    send_frame(0, 40'h6677, 2);
    check("a_timeout_frm_err", frm_seen[0], 1);
    check("a_cmd_6677", cmd_a, 16'h6677);

    // Hold-until-ack policy with overrun.
    send_frame(2, 40'h1111, 2);
    check("c_cmd_1111", cmd_c, 16'h1111);
    send_frame(2, 40'h2222, 2);
    check("c_overrun_once", ovr_seen[2], 1);
    check("c_cmd_2222", cmd_c, 16'h2222);
    check("c_rdy_held", rdy_v[2], 1);
    pulse_clr(2);
    check("c_rdy_cleared_by_ack", rdy_v[2], 0);

    // Bad stop bit on the first byte.
    send_byte(0, 8'h99, 1'b0, r);
    idle(2 * BD);
    check("a_stop_frm_err", frm_seen[0], 2);
    check("a_no_rdy_after_stop_err", rdy_v[0], 0);
    check("a_cmd_kept_6677", cmd_a, 16'h6677);
    send_frame(0, 40'hAABB, 2);
    check("a_cmd_aabb", cmd_a, 16'hAABB);

    // Acknowledge held across the commit: commit wins for that cycle.
    rdy_hi[2] = 0;
    clr_v[2]  = 1'b1;
    send_frame(2, 40'h3333, 2);
    idle(4);
    clr_v[2] = 1'b0;
    m_rdy[2] = 1'b0;
    check("c_commit_beats_clr", rdy_hi[2], 1);
    check("c_cmd_3333", cmd_c, 16'h3333);
    check("c_no_extra_overrun", ovr_seen[2], 1);

    // Reset in the middle of the second byte.
    send_byte(0, 8'h5A, 1'b1, r);
    idle(BD);
    model_start(0);
    rx_v[0] = 1'b0;
    idle(BD);
    rx_v[0] = 1'b1;
    idle(2 * BD);
    rx_v[0] = 1'b0;
    idle(BD);
    rst_n   = 1'b0;
    rx_v[0] = 1'b1;
    idle(2);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("midframe_reset");
    idle(BD);
    send_frame(0, 40'hFFFF, 2);
    check("a_cmd_ffff", cmd_a, 16'hFFFF);
    check("a_rdy_ffff", rdy_v[0], 1);

    idle(BD);
    check("exp_q_drained", exp_q.size(), 0);
    for (int d = 0; d < 3; d++) begin
      check("frm_err_count", frm_seen[d], exp_frm[d]);
      check("chk_err_count", chk_seen[d], exp_chk[d]);
      check("overrun_count", ovr_seen[d], exp_ovr[d]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
